// File: rtl/boot_loader_if.sv
// Byte-stream input and word-write memory port of the boot loader.
// Latency: none (wires only).
// Backpressure: rx_ready from the loader gates the rx_valid/rx_data stream.
interface boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;

  // loader side: consumes the byte stream, drives the memory port
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_a, mem_wd, mem_be
  );

  // host side: produces the byte stream, observes the memory port
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_a, mem_wd, mem_be
  );
endinterface

// File: rtl/boot_loader.sv
// Framed byte-stream boot loader: length, LE payload words, XOR checksum; holds core in reset until verified.
// Latency: one byte per cycle plus one write cycle per word; done/error one cycle after the checksum byte.
// Backpressure: rx_ready drops during each word write and in terminal states; sender holds the byte.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.slave  bus,
  output logic          core_reset,
  output logic          done,
  output logic          error
);
  localparam int          IW   = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAXW = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [1:0]    bcnt;     // byte position within the length field or current word
  logic [IW-1:0] idx;      // words written so far
  logic [7:0]    csum;     // running XOR of payload bytes
  logic [31:0]   len;      // image length in words
  logic [23:0]   word_lo;  // first three bytes of the word being assembled

  logic        xfer;
  logic [31:0] len_full;
  logic [31:0] idx_next;

  assign xfer     = bus.rx_valid & bus.rx_ready;
  // the 4th length byte completes the field in the same cycle it is judged
  assign len_full = {bus.rx_data, len[23:0]};
  assign idx_next = 32'(idx) + 32'd1;

  // single registered FSM: every output is a flop updated alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LEN;
      bcnt       <= 2'd0;
      idx        <= '0;
      csum       <= 8'h00;
      len        <= 32'h0;
      word_lo    <= 24'h0;
      bus.rx_ready <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_a  <= BASE_ADDR;
      bus.mem_wd <= 32'h0;
      bus.mem_be <= 4'h0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_LEN: begin
          bus.rx_ready <= 1'b1;
          if (xfer) begin
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: len[7:0]   <= bus.rx_data;
              2'd1: len[15:8]  <= bus.rx_data;
              2'd2: len[23:16] <= bus.rx_data;
              default: begin
                len <= len_full;
                // full 32-bit compare so huge lengths cannot alias to small ones
                if (len_full == 32'h0 || len_full > MAXW) begin
                  state        <= S_ERR;
                  error        <= 1'b1;
                  bus.rx_ready <= 1'b0;
                end else begin
                  state <= S_DATA;
                end
              end
            endcase
          end
        end

        S_DATA: begin
          bus.rx_ready <= 1'b1;
          if (xfer) begin
            csum <= csum ^ bus.rx_data;
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: word_lo[7:0]   <= bus.rx_data;
              2'd1: word_lo[15:8]  <= bus.rx_data;
              2'd2: word_lo[23:16] <= bus.rx_data;
              default: begin
                // word complete: present the write during the S_WRITE cycle
                state        <= S_WRITE;
                bus.rx_ready <= 1'b0;
                bus.mem_we   <= 1'b1;
                bus.mem_be   <= 4'hF;
                bus.mem_a    <= BASE_ADDR + (32'(idx) << 2);
                bus.mem_wd   <= {bus.rx_data, word_lo};
              end
            endcase
          end
        end

        S_WRITE: begin
          bus.mem_we   <= 1'b0;
          bus.mem_be   <= 4'h0;
          bus.rx_ready <= 1'b1;
          idx          <= idx_next[IW-1:0];
          if (idx_next == len) state <= S_CSUM;
          else                 state <= S_DATA;
        end

        S_CSUM: begin
          bus.rx_ready <= 1'b1;
          if (xfer) begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == csum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        S_DONE: bus.rx_ready <= 1'b0;

        S_ERR: bus.rx_ready <= 1'b0;

        default: begin
          state        <= S_ERR;
          error        <= 1'b1;
          core_reset   <= 1'b1;
          bus.rx_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
